// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the pipeline control blocks.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

endpackage

// File: rtl/hazard_pkg.sv
// Hazard controller states and redirect encoding.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2
  } hazard_state_t;

  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_LU_STALL = LU_STALL;
  localparam logic [1:0] ST_REDIRECT = REDIRECT;

  localparam logic [1:0] PC_SEQ = 2'b00;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and latch enable/flush controls.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if #(
  parameter int NUM_SRC = 2
);
  import cpu_types_pkg::*;

  regbits_t [NUM_SRC-1:0] ifid_src;
  logic [NUM_SRC-1:0]     ifid_src_vld;
  regbits_t               idex_wsel;
  logic                   idex_dREN;
  logic                   exmem_dREN;
  logic                   exmem_dWEN;
  logic                   dhit;
  logic                   ihit;
  logic [1:0]             PCsrc;

  logic pc_enable;
  logic ifid_enable;
  logic idex_enable;
  logic exmem_enable;
  logic ifid_flush;
  logic idex_flush;
  logic memwb_flush;

  modport master (
    output ifid_src, ifid_src_vld, idex_wsel, idex_dREN,
           exmem_dREN, exmem_dWEN, dhit, ihit, PCsrc,
    input  pc_enable, ifid_enable, idex_enable, exmem_enable,
           ifid_flush, idex_flush, memwb_flush
  );

  modport slave (
    input  ifid_src, ifid_src_vld, idex_wsel, idex_dREN,
           exmem_dREN, exmem_dWEN, dhit, ihit, PCsrc,
    output pc_enable, ifid_enable, idex_enable, exmem_enable,
           ifid_flush, idex_flush, memwb_flush
  );

endinterface

// File: rtl/hazard_src_match.sv
// Parallel comparison of every valid IF/ID source field against the EX destination.
module hazard_src_match
  import cpu_types_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  regbits_t [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0]     src_vld,
  input  regbits_t               wsel,
  output logic                   match
);

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      match = match | (src_vld[i] & (src[i] == wsel));
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect bubbles, D-cache freeze, fetch miss.
// Optional HAZARD_CTRL_PERF_EN adds saturating stall/redirect event counters.
module hazard_ctrl
  import cpu_types_pkg::*;
  import hazard_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic         CLK,
  input  logic         RST,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_stall_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);

  localparam int CNT_MAX = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] FL_RELOAD = CNT_W'(FLUSH_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             src_match, lu, mem_wait, redirect;
  logic             pc_en, ifid_en, idex_en, exmem_en;
  logic             ifid_fl, idex_fl, memwb_fl;

  hazard_src_match #(
    .NUM_SRC (NUM_SRC)
  ) u_src_match (
    .src     (bus.ifid_src),
    .src_vld (bus.ifid_src_vld),
    .wsel    (bus.idex_wsel),
    .match   (src_match)
  );

  assign lu       = bus.idex_dREN & (bus.idex_wsel != '0) & src_match;
  assign mem_wait = (bus.exmem_dREN | bus.exmem_dWEN) & ~bus.dhit;
  assign redirect = (bus.PCsrc != PC_SEQ);
  assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

  // Priority: memory freeze, then redirect, then the active multi-cycle state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    idex_en  = 1'b1;
    exmem_en = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    memwb_fl = 1'b0;
    if (mem_wait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_fl = 1'b1;
    end else if (redirect) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
      if (FLUSH_CYC > 1) begin
        state_d = ST_REDIRECT;
        cnt_d   = FL_RELOAD;
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_LU_STALL: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_fl = 1'b1;
          cnt_d   = cnt_dec;
          if (cnt_dec == '0) state_d = ST_RUN;
        end
        ST_REDIRECT: begin
          ifid_fl = 1'b1;
          cnt_d   = cnt_dec;
          if (cnt_dec == '0) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (lu) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_fl = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = ST_LU_STALL;
              cnt_d   = LU_RELOAD;
            end
          end else if (!bus.ihit) begin
            pc_en   = 1'b0;
            ifid_fl = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
    if (RST) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      memwb_fl = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_enable    = pc_en;
  assign bus.ifid_enable  = ifid_en;
  assign bus.idex_enable  = idex_en;
  assign bus.exmem_enable = exmem_en;
  assign bus.ifid_flush   = ifid_fl;
  assign bus.idex_flush   = idex_fl;
  assign bus.memwb_flush  = memwb_fl;

`ifdef HAZARD_CTRL_PERF_EN
  // Stall cycles cover both load-use bubbles and D-cache freezes.
  logic        perf_stall_evt, perf_flush_evt;
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  assign perf_stall_evt = mem_wait |
                          (~redirect & ((state_q == ST_LU_STALL) | ((state_q == ST_RUN) & lu)));
  assign perf_flush_evt = ~mem_wait & redirect;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (perf_stall_evt && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    if (perf_flush_evt && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
